move_cmd_queue: RTL and testbench
=================================

MOVE_CMD_QUEUE -- requirements
Module: move_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; SHALL be a power of 2, >= 2.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 left_p  input  1  one-cycle pulse from the left-button edge detector.
REQ-005 right_p  input  1  one-cycle pulse from the right-button edge detector.
REQ-006 rot_p  input  1  one-cycle pulse from the rotate-button edge detector.
REQ-007 drop_p  input  1  one-cycle pulse from the drop-button edge detector.
REQ-008 cmd_ready  input  1  game logic accepts the head command this cycle.
REQ-009 cmd_valid  output  1  head command is present.
REQ-010 cmd  output  3  head command code; 0 when cmd_valid=0.
REQ-011 count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 lost  output  1  sticky flag; a pulse was coalesced away.

Function
REQ-013 Command codes SHALL be CMD_NONE=0, CMD_LEFT=1, CMD_RIGHT=2, CMD_ROT=3, CMD_DROP=4.
REQ-014 A 4-bit pending register SHALL hold one bit per button; next_pend = pend | {drop_p, rot_p, right_p, left_p}.
REQ-015 Each cycle, if a push slot exists, the highest-priority bit of next_pend SHALL be enqueued and cleared; priority drop > rot > left > right.
REQ-016 A push slot exists when count < DEPTH, or count == DEPTH and a pop occurs in the same cycle.
REQ-017 Exactly one command SHALL be enqueued per cycle maximum; remaining bits stay pending.
REQ-018 A pulse arriving while its bit is already set in pend, and that bit is not cleared this cycle, SHALL set lost; no duplicate is recorded.
REQ-019 Latency: a pulse sampled at edge k with an empty FIFO and no other pending bits SHALL give cmd_valid=1 with its code in the cycle after edge k.
REQ-020 A pop SHALL occur when cmd_valid && cmd_ready; the head is removed at that edge.
REQ-021 cmd_ready with cmd_valid=0 SHALL have no effect.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, including at count == DEPTH and count == 1.
REQ-023 When full and no pop occurs, new pulses SHALL accumulate in pend and be enqueued later in priority order.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 cmd_valid SHALL equal (count != 0); cmd SHALL be the registered head entry.
REQ-026 lost SHALL clear only on reset.

Reset
REQ-027 Assertion of reset SHALL immediately clear: pend=0, pointers=0, count=0, cmd_valid=0, cmd=0, lost=0.
REQ-028 Pulses coincident with reset assertion SHALL be discarded.
REQ-029 Pulses at the first edge after deassertion SHALL be accepted.
REQ-030 Reset asserted mid-operation SHALL discard all queued and pending commands.

Structure
REQ-031 The cmd_t enum (3-bit codes) and the CMD_* constants SHALL live in a shared package, tetris_pkg, for reuse by game logic.
REQ-032 The FIFO SHALL be a sub-module cmd_fifo, parameterized by DEPTH and entry width.
REQ-033 The pending register and priority encoder SHALL remain in move_cmd_queue.

Verification
REQ-034 Scenario 1: reset low 2 cycles, then left_p pulse with cmd_ready=0 -> next cycle cmd_valid=1, cmd=1, count=1; cmd_ready=1 one cycle -> count=0, cmd=0.
REQ-035 Scenario 2: all four pulses in the same cycle, cmd_ready=1 held -> codes 4, 3, 1, 2 on consecutive cycles; lost=0.
REQ-036 Scenario 3: cmd_ready=0, DEPTH=4, six distinct-cycle pulses (rot, left, right, drop, left, rot) -> count saturates at 4; pend holds left+rot; after draining, order is 3, 1, 2, 4, 3, 1.
REQ-037 Scenario 4: full FIFO, left already pending, another left_p -> lost=1 and stays 1 until reset.
REQ-038 Scenario 5: count == DEPTH, push and pop in the same cycle -> count stays at DEPTH; head advances one entry.
REQ-039 Scenario 6: reset asserted mid-drain with count=3 -> outputs zero asynchronously; after release, a drop_p yields cmd=4 alone.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared game types: move command codes and button bit positions.
// Used by the command queue and by downstream game logic.
package tetris_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_NONE  = 3'd0,
    CMD_LEFT  = 3'd1,
    CMD_RIGHT = 3'd2,
    CMD_ROT   = 3'd3,
    CMD_DROP  = 3'd4
  } cmd_t;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_ROT   = 2;
  localparam int BTN_DROP  = 3;

endpackage

// File: rtl/move_cmd_queue_if.sv
// Button pulses in, head-of-queue command out with valid/ready.
// master drives pulses and ready; slave is the queue.
interface move_cmd_queue_if
  import tetris_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic          left_p;
  logic          right_p;
  logic          rot_p;
  logic          drop_p;
  logic          cmd_ready;
  logic          cmd_valid;
  cmd_t          cmd;
  logic [CW-1:0] count;
  logic          lost;

  modport master (
    output left_p, right_p, rot_p, drop_p,
    output cmd_ready,
    input  cmd_valid, cmd, count, lost
  );

  modport slave (
    input  left_p, right_p, rot_p, drop_p,
    input  cmd_ready,
    output cmd_valid, cmd, count, lost
  );

endinterface

// File: rtl/move_cmd_queue_cmd_fifo.sv
// Small power-of-2 FIFO; head is presented combinationally
// from storage and forced to zero while empty.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          empty;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/move_cmd_queue.sv
// Coalesces button pulses into a pending set and enqueues at
// most one command per cycle, highest priority first.
module move_cmd_queue
  import tetris_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  move_cmd_queue_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [3:0]       pulse;
  logic [3:0]       pend;
  logic [3:0]       nxt;
  logic [3:0]       sel;
  logic [3:0]       clr;
  cmd_t             code;
  logic             pop;
  logic             push;
  logic             full;
  logic             lost_q;
  logic [CMD_W-1:0] head;
  logic [CW-1:0]    cnt;

  assign pulse = {bus.drop_p, bus.rot_p,
                  bus.right_p, bus.left_p};
  assign nxt   = pend | pulse;

  // Left outranks right on purpose; order is drop>rot>left>right.
  always_comb begin
    sel  = '0;
    code = CMD_NONE;
    priority case (1'b1)
      nxt[BTN_DROP]: begin
        sel[BTN_DROP] = 1'b1;
        code          = CMD_DROP;
      end
      nxt[BTN_ROT]: begin
        sel[BTN_ROT] = 1'b1;
        code         = CMD_ROT;
      end
      nxt[BTN_LEFT]: begin
        sel[BTN_LEFT] = 1'b1;
        code          = CMD_LEFT;
      end
      nxt[BTN_RIGHT]: begin
        sel[BTN_RIGHT] = 1'b1;
        code           = CMD_RIGHT;
      end
      default: begin
        sel  = '0;
        code = CMD_NONE;
      end
    endcase
  end

  assign pop  = bus.cmd_valid && bus.cmd_ready;
  assign push = (code != CMD_NONE) && (!full || pop);
  assign clr  = push ? sel : 4'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend   <= '0;
      lost_q <= 1'b0;
    end else begin
      pend   <= nxt & ~clr;
      lost_q <= lost_q | (|(pulse & pend & ~clr));
    end
  end

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (code),
    .pop   (pop),
    .dout  (head),
    .count (cnt),
    .full  (full)
  );

  assign bus.cmd       = cmd_t'(head);
  assign bus.count     = cnt;
  assign bus.cmd_valid = (cnt != '0);
  assign bus.lost      = lost_q;

endmodule

// File: tb/tb_move_cmd_queue.sv
// Scoreboard bench: stimulus queues expected codes, a negedge
// monitor checks every accepted command against the queue.
module tb_move_cmd_queue;
  import tetris_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  move_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

  move_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mask bits: 0 left, 1 right, 2 rot, 3 drop
  task automatic pulse(logic [3:0] m);
    bus.left_p  = m[0];
    bus.right_p = m[1];
    bus.rot_p   = m[2];
    bus.drop_p  = m[3];
    tick();
    bus.left_p  = 1'b0;
    bus.right_p = 1'b0;
    bus.rot_p   = 1'b0;
    bus.drop_p  = 1'b0;
  endtask

  task automatic expect_code(int c);
    exp_q.push_back(3'(c));
  endtask

  always @(negedge clk) begin
    if (reset && !bus.cmd_valid)
      chk("idle_cmd_zero", int'(bus.cmd), 0);
    if (reset && bus.cmd_valid && bus.cmd_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd", int'(bus.cmd), 0);
      end else begin
        chk("sb_cmd", int'(bus.cmd), int'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.left_p    = 1'b0;
    bus.right_p   = 1'b0;
    bus.rot_p     = 1'b0;
    bus.drop_p    = 1'b0;
    bus.cmd_ready = 1'b0;

    // Scenario 1: reset, single left
    tick();
    bus.left_p = 1'b1;
    tick();
    bus.left_p = 1'b0;
    chk("rst_valid", int'(bus.cmd_valid), 0);
    chk("rst_cmd", int'(bus.cmd), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_lost", int'(bus.lost), 0);
    reset = 1'b1;
    expect_code(1);
    pulse(4'b0001);
    chk("s1_valid", int'(bus.cmd_valid), 1);
    chk("s1_cmd", int'(bus.cmd), 1);
    chk("s1_count", int'(bus.count), 1);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    chk("s1_count_pop", int'(bus.count), 0);
    chk("s1_cmd_pop", int'(bus.cmd), 0);
    tick();

    // Scenario 2: all four at once, ready held
    bus.cmd_ready = 1'b1;
    expect_code(4);
    expect_code(3);
    expect_code(1);
    expect_code(2);
    pulse(4'b1111);
    chk("s2_head1", int'(bus.cmd), 4);
    chk("s2_count1", int'(bus.count), 1);
    tick();
    chk("s2_head2", int'(bus.cmd), 3);
    chk("s2_count2", int'(bus.count), 1);
    tick();
    tick();
    tick();
    chk("s2_count_end", int'(bus.count), 0);
    chk("s2_lost", int'(bus.lost), 0);
    bus.cmd_ready = 1'b0;

    // Scenario 3: saturate then drain pending in order
    foreach (exp_q[i]) ;
    expect_code(3);
    expect_code(1);
    expect_code(2);
    expect_code(4);
    expect_code(3);
    expect_code(1);
    pulse(4'b0100); tick();
    pulse(4'b0001); tick();
    pulse(4'b0010); tick();
    pulse(4'b1000); tick();
    chk("s3_full", int'(bus.count), 4);
    pulse(4'b0001); tick();
    pulse(4'b0100); tick();
    chk("s3_sat", int'(bus.count), 4);
    chk("s3_lost", int'(bus.lost), 0);
    bus.cmd_ready = 1'b1;
    tick();
    chk("s3_refill", int'(bus.count), 4);
    for (int i = 0; i < 5; i++) tick();
    chk("s3_drained", int'(bus.count), 0);
    bus.cmd_ready = 1'b0;

    // Scenario 5: full, push and pop same cycle
    expect_code(1);
    expect_code(2);
    expect_code(3);
    expect_code(4);
    expect_code(1);
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0100);
    pulse(4'b1000);
    chk("s5_full", int'(bus.count), 4);
    bus.cmd_ready = 1'b1;
    pulse(4'b0001);
    bus.cmd_ready = 1'b0;
    chk("s5_count", int'(bus.count), 4);
    chk("s5_head", int'(bus.cmd), 2);
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("s5_drained", int'(bus.count), 0);
    bus.cmd_ready = 1'b0;

    // Scenario 4: duplicate left while full sets lost
    expect_code(4);
    expect_code(3);
    expect_code(2);
    expect_code(4);
    expect_code(1);
    pulse(4'b1000);
    pulse(4'b0100);
    pulse(4'b0010);
    pulse(4'b1000);
    pulse(4'b0001);
    chk("s4_no_lost", int'(bus.lost), 0);
    pulse(4'b0001);
    chk("s4_lost", int'(bus.lost), 1);
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.cmd_ready = 1'b0;
    chk("s4_drained", int'(bus.count), 0);
    chk("s4_sticky", int'(bus.lost), 1);

    // Scenario 6: reset mid-drain
    pulse(4'b0100);
    pulse(4'b0010);
    pulse(4'b0001);
    chk("s6_count", int'(bus.count), 3);
    reset = 1'b0;
    #1;
    chk("s6_async_valid", int'(bus.cmd_valid), 0);
    chk("s6_async_count", int'(bus.count), 0);
    chk("s6_async_lost", int'(bus.lost), 0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    expect_code(4);
    pulse(4'b1000);
    chk("s6_cmd", int'(bus.cmd), 4);
    chk("s6_count1", int'(bus.count), 1);
    bus.cmd_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.cmd_ready = 1'b0;
    chk("s6_empty", int'(bus.count), 0);
    chk("sb_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
